// File: rtl/redmule_mx_dec_arbiter.sv
// rtl/redmule_mx_dec_arbiter.sv - per-block round-robin arbiter sharing one MX decoder
// A grant covers one value beat, one exponent beat and all decoded beats of that block.
module redmule_mx_dec_arbiter #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_val_valid_i,
  output logic [NUM_REQ-1:0]            req_val_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]     req_val_data_i,
  input  logic [NUM_REQ-1:0]            req_exp_valid_i,
  output logic [NUM_REQ-1:0]            req_exp_ready_o,
  input  logic [NUM_REQ*8-1:0]          req_exp_data_i,
  output logic [NUM_REQ-1:0]            req_fp16_valid_o,
  input  logic [NUM_REQ-1:0]            req_fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0]     req_fp16_data_o,
  output logic                          dec_val_valid_o,
  input  logic                          dec_val_ready_i,
  output logic [DATA_W-1:0]             dec_val_data_o,
  output logic                          dec_exp_valid_o,
  input  logic                          dec_exp_ready_i,
  output logic [7:0]                    dec_exp_data_o,
  input  logic                          dec_fp16_valid_i,
  output logic                          dec_fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0]     dec_fp16_data_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o
);

  localparam int unsigned NUM_ELEMS = DATA_W / 8;
  localparam int unsigned BEATS     = NUM_ELEMS / NUM_LANES;
  localparam int unsigned CNT_W     = $clog2(BEATS + 1);
  localparam int unsigned OW        = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             val_done_q, val_done_d;
  logic             exp_done_q, exp_done_d;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [OW-1:0]      grant_idx;
  logic [OW-1:0]      grant_next;
  logic               val_hs, exp_hs;
  int unsigned        scan_idx;

  assign eligible = req_val_valid_i & req_exp_valid_i;

  // Scan starts at rr_ptr so the last winner goes to the back of the line.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_next  = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = OW'(scan_idx);
        grant_next  = OW'((scan_idx + 1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    beat_cnt_d       = beat_cnt_q;
    val_done_d       = val_done_q;
    exp_done_d       = exp_done_q;
    req_val_ready_o  = '0;
    req_exp_ready_o  = '0;
    req_fp16_valid_o = '0;
    dec_val_valid_o  = 1'b0;
    dec_exp_valid_o  = 1'b0;
    dec_fp16_ready_o = 1'b0;
    val_hs           = 1'b0;
    exp_hs           = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d  = grant_idx;
          rr_ptr_d = grant_next;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        dec_val_valid_o          = req_val_valid_i[owner_q] && !val_done_q;
        req_val_ready_o[owner_q] = dec_val_ready_i && !val_done_q;
        dec_exp_valid_o          = req_exp_valid_i[owner_q] && !exp_done_q;
        req_exp_ready_o[owner_q] = dec_exp_ready_i && !exp_done_q;
        val_hs = dec_val_valid_o && dec_val_ready_i;
        exp_hs = dec_exp_valid_o && dec_exp_ready_i;
        if ((val_done_q || val_hs) && (exp_done_q || exp_hs)) begin
          state_d    = DRAIN;
          val_done_d = 1'b0;
          exp_done_d = 1'b0;
        end else begin
          val_done_d = val_done_q || val_hs;
          exp_done_d = exp_done_q || exp_hs;
        end
      end
      DRAIN: begin
        req_fp16_valid_o[owner_q] = dec_fp16_valid_i;
        dec_fp16_ready_o          = req_fp16_ready_i[owner_q];
        if (dec_fp16_valid_i && req_fp16_ready_i[owner_q]) begin
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dec_val_data_o  = req_val_data_i[owner_q*DATA_W +: DATA_W];
  assign dec_exp_data_o  = req_exp_data_i[owner_q*8 +: 8];
  assign req_fp16_data_o = dec_fp16_data_i;
  assign busy_o          = (state_q != IDLE);
  assign owner_o         = owner_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      val_done_q <= 1'b0;
      exp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      val_done_q <= val_done_d;
      exp_done_q <= exp_done_d;
    end
  end

endmodule

// File: doc/redmule_mx_dec_arbiter.md
Name: redmule_mx_dec_arbiter

Overview:
- Shares one redmule_mx_decoder between NUM_REQ MX block sources (e.g. X and W operand streamers).
- Arbitration is per block, round-robin. A granted requester owns the decoder for exactly one block: one value beat, one shared-exponent beat, then all BEATS FP16 output beats.
- Decoded FP16 beats are routed back to the owner only, so blocks from different requesters never interleave under one shared exponent.
- Sits between the streamer MX ports and the decoder instance.

Parameters:
- DATA_W, 256, width of one MX value beat; one beat is one block of NUM_ELEMS = DATA_W/8 FP8 elements.
- BITW, 16, FP16 lane width.
- NUM_LANES, 4, FP16 lanes per decoder output beat.
- NUM_REQ, 2, number of requesters (≥2).
- Derived: BEATS = NUM_ELEMS/NUM_LANES (8 at defaults); CNT_W = $clog2(BEATS+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_val_valid_i  in  NUM_REQ  per-requester MX value valid
- req_val_ready_o  out  NUM_REQ  per-requester MX value ready
- req_val_data_i  in  NUM_REQ*DATA_W  flattened value data, requester r at [r*DATA_W +: DATA_W]
- req_exp_valid_i  in  NUM_REQ  shared-exponent valid
- req_exp_ready_o  out  NUM_REQ  shared-exponent ready
- req_exp_data_i  in  NUM_REQ*8  flattened exponents
- req_fp16_valid_o  out  NUM_REQ  decoded FP16 valid to requester
- req_fp16_ready_i  in  NUM_REQ  decoded FP16 ready from requester
- req_fp16_data_o  out  NUM_LANES*BITW  decoded data, broadcast to all requesters; qualified by req_fp16_valid_o
- dec_val_valid_o / dec_val_ready_i / dec_val_data_o  out/in/out  1/1/DATA_W  to decoder value port
- dec_exp_valid_o / dec_exp_ready_i / dec_exp_data_o  out/in/out  1/1/8  to decoder exponent port
- dec_fp16_valid_i / dec_fp16_ready_o / dec_fp16_data_i  in/out/in  1/1/NUM_LANES*BITW  from decoder
- busy_o  out  1  state != IDLE
- owner_o  out  $clog2(NUM_REQ)  current owner, valid while busy_o

Behaviour:
- Reset (async, any state):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, val_done=exp_done=0.
  - All valid/ready outputs 0; busy_o=0.
- Eligibility: requester r is eligible iff req_val_valid_i[r] && req_exp_valid_i[r]. A requester with only one of the two asserted is never granted.
- IDLE:
  - All readies and dec valids are 0.
  - Grant the first eligible r scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - On grant: owner<=r, rr_ptr<=(r+1) mod NUM_REQ, go to ISSUE.
  - No eligible requester: stay in IDLE.
- ISSUE:
  - Value path: dec_val_valid_o = req_val_valid_i[owner] && !val_done; dec_val_data_o = owner slice; req_val_ready_o[owner] = dec_val_ready_i && !val_done.
  - Exponent path: identical rule using exp_done.
  - The two handshakes are independent and may complete in the same or different cycles. Each sets its done flag.
  - When both are done (counting a handshake in the current cycle), go to DRAIN and clear both flags.
  - Non-owner readies are always 0.
- DRAIN:
  - req_fp16_valid_o[owner] = dec_fp16_valid_i; all other bits 0.
  - dec_fp16_ready_o = req_fp16_ready_i[owner].
  - Each handshake increments beat_cnt.
  - The handshake with beat_cnt==BEATS-1 clears beat_cnt and returns to IDLE.
  - The next grant is decided in the following IDLE cycle.
- Outside DRAIN, dec_fp16_ready_o=0 and FP16 beats from the decoder stall.
- Latency: eligible → dec valids high 1 cycle later. Minimum cycles per block = 1 (IDLE) + 1 (ISSUE) + BEATS (DRAIN).
- Owner's valid drops mid-ISSUE: handshake waits; no regrant.
- Owner backpressure in DRAIN: the decoder stalls; no beat is lost or duplicated.
- Non-owner requests are held off until the owner's block completes.

Test Plan:
- Single requester: req0 sends val=random, exp=0x7F; decoder ready → grant in the IDLE cycle, one val and one exp handshake, exactly 8 FP16 beats on req_fp16_valid_o[0] and none on [1]; data matches a standalone decoder.
- Both requesters eligible continuously for 4 blocks → owner sequence 0,1,0,1; each requester receives 8 beats per block with its own exponent.
- req1 has val but no exp for 20 cycles while req0 is eligible → only req0 is granted. Once req1's exp arrives, req1 wins the next arbitration.
- dec_exp_ready_i held low 5 cycles after the val handshake → state stays ISSUE; no second val handshake; DRAIN starts the cycle after the exp handshake.
- Owner req_fp16_ready_i toggling 1,0,0,1… during DRAIN → exactly 8 beats delivered in order; dec_fp16_ready_o mirrors the owner ready.
- rst_ni pulsed low at DRAIN beat 3 → all outputs 0 immediately, state IDLE, owner 0. After release, a fresh block completes normally with rr_ptr=0.
